instruction_encoder_loader: RTL and testbench

- Encodes RV64I instruction fields (format, opcode, registers, funct, 64-bit signed immediate) into 32-bit instruction words.
- Writes each word sequentially into instruction memory through a valid/ack write port.
- It is the inverse of the immediate data generator: it packs immediates into the bit positions the generator unpacks.
- Sits between the bench/boot source and instruction memory, and is used to load programs before the core runs.

---
 rtl/instruction_encoder_loader_pkg.sv | 30 +++
 rtl/instruction_encoder_loader_if.sv | 39 +++
 rtl/instruction_encoder_loader_instr_field_packer.sv | 49 ++++
 rtl/instruction_encoder_loader.sv | 101 ++++++++++
 tb/tb_instruction_encoder_loader.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: format codes,
// the base opcodes also used by the decoder, the FSM state type and a
// small signed-range helper used by the field packer.
package instruction_encoder_loader_pkg;

  localparam logic [1:0] FMT_R  = 2'd0;
  localparam logic [1:0] FMT_I  = 2'd1;
  localparam logic [1:0] FMT_S  = 2'd2;
  localparam logic [1:0] FMT_SB = 2'd3;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // True when v is a sign extension of its low (msb+1) bits, i.e. it lies in
  // -2^msb .. 2^msb-1. Checked as "all bits from msb upward are equal".
  function automatic logic fits_signed(input logic [63:0] v, input int unsigned msb);
    logic [63:0] hi;
    hi = 64'($signed(v) >>> msb);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instruction_encoder_loader_if.sv
// Bundle-in / memory-write-out signal group of the encoder/loader.
//
// Handshakes: a field bundle transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends on loader state only. A memory
// write is offered while mem_we is high, with mem_addr/mem_wdata held stable,
// and completes on the rising edge where mem_ack is high (mem_ack may already
// be high in the first cycle of mem_we).
//
// master: the program source, which also plays the memory and returns mem_ack.
// slave:  the encoder/loader itself.
interface instruction_encoder_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm;
  logic        last;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instruction_encoder_loader_instr_field_packer.sv
// Combinational RV64I field packer: places register/funct fields and the
// immediate into the bit positions the immediate generator unpacks them from.
// imm_err flags an immediate that cannot be represented; the word is still
// produced from the truncated bits.
module instr_field_packer
  import instruction_encoder_loader_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] imm,
  output logic [31:0] word,
  output logic        imm_err
);

  // Per-format bit placement and immediate range check.
  always_comb begin
    word    = '0;
    imm_err = 1'b0;
    unique case (fmt)
      FMT_R: begin
        // Register-register: immediate is not part of the encoding.
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        word    = {imm[11:0], rs1, funct3, rd, opcode};
        imm_err = !fits_signed(imm, 11);
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        imm_err = !fits_signed(imm, 11);
      end
      FMT_SB: begin
        // Branch offsets are even byte offsets; bit 0 is not encoded.
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        imm_err = !fits_signed(imm, 12) || imm[0];
      end
      default: begin
        word    = '0;
        imm_err = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Program loader: accepts encoded-field bundles, packs each into a 32-bit
// instruction word and writes the words to consecutive memory addresses
// starting at BASE_ADDR. Stops on a bundle marked last or when the memory is
// full, and can be restarted from DONE with a start pulse.
module instruction_encoder_loader
  import instruction_encoder_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          DEPTH_WORDS = 16,
  localparam int         CW          = $clog2(DEPTH_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  instruction_encoder_loader_if.slave bus,
  output logic [CW-1:0]               count,
  output logic                        done,
  output logic [1:0]                  err,
  output state_t                      state
);

  logic [31:0]   word;
  logic          imm_err;
  logic [CW-1:0] count_inc;
  logic [63:0]   addr_next;
  logic          last_q;

  instr_field_packer u_packer (
    .fmt     (bus.fmt),
    .opcode  (bus.opcode),
    .rd      (bus.rd),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .imm     (bus.imm),
    .word    (word),
    .imm_err (imm_err)
  );

  assign count_inc = count + CW'(1);
  // Word-addressed offset from the base; wraps naturally at 2^64.
  assign addr_next = BASE_ADDR + (64'(count) << 2);

  // Ready is a pure function of state so the source never sees a loop.
  assign bus.in_ready = (state == ST_ACCEPT);

  // Load sequencer: accept a bundle, hold the write until acked, then either
  // take the next bundle or finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_ACCEPT;
      count         <= '0;
      err           <= '0;
      done          <= 1'b0;
      last_q        <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= '0;
    end else begin
      unique case (state)
        ST_ACCEPT: begin
          if (bus.in_valid) begin
            bus.mem_wdata <= word;
            bus.mem_addr  <= addr_next;
            bus.mem_we    <= 1'b1;
            last_q        <= bus.last;
            if (imm_err) err[0] <= 1'b1;
            state         <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.mem_ack) begin
            bus.mem_we <= 1'b0;
            count      <= count_inc;
            if (last_q || (count_inc == CW'(DEPTH_WORDS))) begin
              state <= ST_DONE;
              done  <= 1'b1;
              // Running out of room before the program ended is an error.
              if (!last_q) err[1] <= 1'b1;
            end else begin
              state <= ST_ACCEPT;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            count <= '0;
            err   <= '0;
            done  <= 1'b0;
            state <= ST_ACCEPT;
          end
        end
        default: begin
          state <= ST_ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Bench for instruction_encoder_loader: a table of field bundles with
// hand-encoded words is loaded into a 16-word instance, followed by
// multi-cycle sequences (DONE/start behaviour, reset mid-stall) and a 2-word
// instance whose base sits just below 2^64 to exercise fill-up and wrap.
module tb_instruction_encoder_loader;
  import instruction_encoder_loader_pkg::*;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] BASE2 = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          NVEC  = 13;

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic        last;
    int          ack_delay;
    logic [31:0] exp_word;
    logic        bad_imm;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic start2;
  always #5 clk = ~clk;

  logic [4:0] count;
  logic       done;
  logic [1:0] err;
  state_t     state;
  logic [1:0] count2;
  logic       done2;
  logic [1:0] err2;
  state_t     state2;

  instruction_encoder_loader_if bus ();
  instruction_encoder_loader_if bus2 ();

  instruction_encoder_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus.slave),
    .count (count),
    .done  (done),
    .err   (err),
    .state (state)
  );

  instruction_encoder_loader #(.BASE_ADDR(BASE2), .DEPTH_WORDS(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .bus   (bus2.slave),
    .count (count2),
    .done  (done2),
    .err   (err2),
    .state (state2)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [95:0] exp_q[$];
  logic [4:0]  exp_count;
  logic [1:0]  exp_err;
  vec_t        vecs[NVEC];

  task automatic chk(input string tag, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s actual=%h expected=%h", tag, name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input vec_t v);
    bus.fmt    = v.fmt;
    bus.opcode = v.opcode;
    bus.rd     = v.rd;
    bus.rs1    = v.rs1;
    bus.rs2    = v.rs2;
    bus.funct3 = v.funct3;
    bus.funct7 = v.funct7;
    bus.imm    = v.imm;
    bus.last   = v.last;
  endtask

  task automatic drive2_addi(input int k);
    bus2.fmt    = FMT_I;
    bus2.opcode = OP_IMM;
    bus2.rd     = 5'd1;
    bus2.rs1    = 5'd0;
    bus2.rs2    = 5'd0;
    bus2.funct3 = 3'd0;
    bus2.funct7 = 7'd0;
    bus2.imm    = 64'(k);
    bus2.last   = 1'b0;
  endtask

  // One full transaction on the 16-word instance: offer, accept, stall for
  // ack_delay cycles, ack, and check the resulting counters and flags.
  task automatic run_vec(input vec_t v, input string tag);
    logic [95:0] e;
    @(negedge clk);
    drive(v);
    bus.in_valid = 1'b1;
    chk(tag, "in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back({BASE + (64'(exp_count) << 2), v.exp_word});
    @(negedge clk);
    bus.in_valid = 1'b0;
    e = exp_q.pop_front();
    chk(tag, "mem_we", 64'(bus.mem_we), 64'd1);
    chk(tag, "busy_ready", 64'(bus.in_ready), 64'd0);
    chk(tag, "addr", bus.mem_addr, e[95:32]);
    chk(tag, "word", 64'(bus.mem_wdata), 64'(e[31:0]));
    for (int d = 0; d < v.ack_delay; d++) begin
      @(negedge clk);
      chk(tag, "stall_we", 64'(bus.mem_we), 64'd1);
      chk(tag, "stall_addr", bus.mem_addr, e[95:32]);
      chk(tag, "stall_word", 64'(bus.mem_wdata), 64'(e[31:0]));
      chk(tag, "stall_count", 64'(count), 64'(exp_count));
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    exp_count++;
    if (v.bad_imm) exp_err[0] = 1'b1;
    chk(tag, "count", 64'(count), 64'(exp_count));
    chk(tag, "we_drop", 64'(bus.mem_we), 64'd0);
    chk(tag, "done", 64'(done), 64'(v.last));
    chk(tag, "err", 64'(err), 64'(exp_err));
    chk(tag, "next_ready", 64'(bus.in_ready), 64'(!v.last));
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    logic [63:0] a2;
    logic [31:0] w2;

    vecs[0]  = '{FMT_I,  OP_IMM,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0,  64'd5,                  1'b0, 0, 32'h00500293, 1'b0};
    vecs[1]  = '{FMT_S,  OP_STORE,  5'd0, 5'd5, 5'd5, 3'd2, 7'd0,  64'd0,                  1'b0, 1, 32'h0052A023, 1'b0};
    vecs[2]  = '{FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0,  64'd4,                  1'b0, 0, 32'h00001263, 1'b0};
    vecs[3]  = '{FMT_R,  OP_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0,  64'd0,                  1'b0, 3, 32'h002081B3, 1'b0};
    vecs[4]  = '{FMT_R,  OP_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'h8000_0000_0000_0001, 1'b0, 0, 32'h402081B3, 1'b0};
    vecs[5]  = '{FMT_I,  OP_IMM,    5'd1, 5'd2, 5'd0, 3'd0, 7'd0,  -64'sd2048,             1'b0, 0, 32'h80010093, 1'b0};
    vecs[6]  = '{FMT_I,  OP_IMM,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  64'd2047,               1'b0, 2, 32'h7FF00013, 1'b0};
    vecs[7]  = '{FMT_S,  OP_STORE,  5'd0, 5'd4, 5'd3, 3'd2, 7'd0,  -64'sd1,                1'b0, 0, 32'hFE322FA3, 1'b0};
    vecs[8]  = '{FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  -64'sd4096,             1'b0, 0, 32'h80000063, 1'b0};
    vecs[9]  = '{FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  64'd4094,               1'b0, 1, 32'h7E000FE3, 1'b0};
    vecs[10] = '{FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0,  64'd3,                  1'b0, 0, 32'h00001163, 1'b1};
    vecs[11] = '{FMT_I,  OP_IMM,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  64'd2048,               1'b0, 0, 32'h80000013, 1'b1};
    vecs[12] = '{FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  64'd4096,               1'b1, 0, 32'h80000063, 1'b1};

    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.mem_ack  = 1'b0;
    drive(vecs[0]);
    drive2_addi(0);
    exp_count = '0;
    exp_err   = '0;

    // Reset values.
    #1;
    chk("reset", "mem_we", 64'(bus.mem_we), 64'd0);
    chk("reset", "count", 64'(count), 64'd0);
    chk("reset", "done", 64'(done), 64'd0);
    chk("reset", "err", 64'(err), 64'd0);
    chk("reset", "mem_addr", bus.mem_addr, BASE);
    chk("reset", "mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("reset", "state", 64'(state), 64'(ST_ACCEPT));
    chk("reset", "in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset", "mem_addr2", bus2.mem_addr, BASE2);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table of bundles; the last one ends the program.
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Bundles offered in DONE are ignored.
    @(negedge clk);
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("done_ign", "mem_we", 64'(bus.mem_we), 64'd0);
      chk("done_ign", "count", 64'(count), 64'(NVEC));
      chk("done_ign", "state", 64'(state), 64'(ST_DONE));
    end
    bus.in_valid = 1'b0;

    // start in DONE clears count and err.
    pulse_start();
    chk("restart", "count", 64'(count), 64'd0);
    chk("restart", "err", 64'(err), 64'd0);
    chk("restart", "done", 64'(done), 64'd0);
    chk("restart", "state", 64'(state), 64'(ST_ACCEPT));
    exp_count = '0;
    exp_err   = '0;

    // Store then branch-with-last; a start pulse in between is ignored.
    run_vec(vecs[1], "sw");
    pulse_start();
    chk("start_ign", "count", 64'(count), 64'd1);
    chk("start_ign", "state", 64'(state), 64'(ST_ACCEPT));
    v = vecs[2];
    v.last = 1'b1;
    run_vec(v, "bne_last");
    chk("bne_last", "count2", 64'(count), 64'd2);

    // Reset asserted in the middle of a stalled write.
    pulse_start();
    exp_count = '0;
    exp_err   = '0;
    run_vec(vecs[0], "pre_rst");
    @(negedge clk);
    drive(vecs[3]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rst_mid", "we_before", 64'(bus.mem_we), 64'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid", "mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mid", "count", 64'(count), 64'd0);
    chk("rst_mid", "state", 64'(state), 64'(ST_ACCEPT));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rel", "in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_rel", "mem_addr", bus.mem_addr, BASE);
    chk("rst_rel", "mem_wdata", 64'(bus.mem_wdata), 64'd0);
    exp_count = '0;
    exp_err   = '0;
    run_vec(vecs[0], "post_rst");

    // Two-word memory near the top of the address space: fills up, wraps.
    for (int k = 0; k < 2; k++) begin
      a2 = (k == 0) ? BASE2 : 64'h0;
      w2 = (k == 0) ? 32'h00000093 : 32'h00100093;
      @(negedge clk);
      drive2_addi(k);
      bus2.in_valid = 1'b1;
      chk("fill", "in_ready", 64'(bus2.in_ready), 64'd1);
      @(negedge clk);
      bus2.in_valid = 1'b0;
      chk("fill", "mem_we", 64'(bus2.mem_we), 64'd1);
      chk("fill", "addr", bus2.mem_addr, a2);
      chk("fill", "word", 64'(bus2.mem_wdata), 64'(w2));
      bus2.mem_ack = 1'b1;
      @(negedge clk);
      bus2.mem_ack = 1'b0;
      chk("fill", "count", 64'(count2), 64'(k + 1));
    end
    chk("full", "done", 64'(done2), 64'd1);
    chk("full", "err", 64'(err2), 64'd2);
    chk("full", "state", 64'(state2), 64'(ST_DONE));
    chk("full", "in_ready", 64'(bus2.in_ready), 64'd0);

    // Third bundle is never accepted.
    @(negedge clk);
    drive2_addi(2);
    bus2.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("third", "mem_we", 64'(bus2.mem_we), 64'd0);
      chk("third", "count", 64'(count2), 64'd2);
    end
    bus2.in_valid = 1'b0;

    // start clears the overflow and the next write goes to the base again.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("full_restart", "err", 64'(err2), 64'd0);
    chk("full_restart", "count", 64'(count2), 64'd0);
    chk("full_restart", "done", 64'(done2), 64'd0);
    drive2_addi(0);
    bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    chk("full_restart", "addr", bus2.mem_addr, BASE2);
    chk("full_restart", "word", 64'(bus2.mem_wdata), 64'h0000_0093);
    bus2.mem_ack = 1'b1;
    @(negedge clk);
    bus2.mem_ack = 1'b0;
    chk("full_restart", "count1", 64'(count2), 64'd1);

    // Final report.
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
